// File: rtl/elevator_controller.sv
// Single-car SCAN elevator controller: latches calls, times travel and door dwell from My_Clock.
// Optional door-hold input is enabled by defining ELEVATOR_DOOR_HOLD_EN.
module elevator_controller #(
  parameter int FLOORS       = 4,
  parameter int TRAVEL_TICKS = 2,
  parameter int DOOR_TICKS   = 3,
  localparam int FW          = (FLOORS > 2) ? $clog2(FLOORS) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              My_Clock,
  input  logic [FLOORS-1:0] interior_panel,
  input  logic [FLOORS-1:0] exterior_panel,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic              door_hold,
`endif
  output logic [1:0]        engine,
  output logic [FLOORS-1:0] doors,
  output logic [FW-1:0]     floor,
  output logic [FLOORS-1:0] pending
);

  localparam int TW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [TW-1:0] TRAVEL_MAX = TW'(TRAVEL_TICKS - 1);
  localparam logic [DW-1:0] DOOR_MAX   = DW'(DOOR_TICKS - 1);
  localparam logic [FLOORS-1:0] ONE    = FLOORS'(1);
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR} state_e;

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [FW-1:0]     floor_q, floor_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [DW-1:0]     dcnt_q, dcnt_d;
  logic [FLOORS-1:0] pending_q, pending_d;
  logic [1:0]        engine_q, engine_d;
  logic [FLOORS-1:0] doors_q, doors_d;

  logic [FLOORS-1:0] calls, req, served;
  logic [FLOORS-1:0] above_cur, below_cur, above_step, below_step;
  logic [FW-1:0]     floor_step;
  logic              ahead_cur, behind_cur, ahead_step, hold;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  assign calls      = interior_panel | exterior_panel;
  assign req        = pending_q | calls;
  assign floor_step = (dir_q == DIR_DN) ? floor_q - FW'(1) : floor_q + FW'(1);

  // Floor-relative masks for the current floor and the floor about to be reached.
  for (genvar gi = 0; gi < FLOORS; gi++) begin : g_masks
    assign above_cur[gi]  = FW'(gi) > floor_q;
    assign below_cur[gi]  = FW'(gi) < floor_q;
    assign above_step[gi] = FW'(gi) > floor_step;
    assign below_step[gi] = FW'(gi) < floor_step;
  end

  // IDLE decisions see only latched requests; arrival checks also see same-cycle calls.
  assign ahead_cur  = (dir_q == DIR_DN) ? |(pending_q & below_cur) : |(pending_q & above_cur);
  assign behind_cur = (dir_q == DIR_DN) ? |(pending_q & above_cur) : |(pending_q & below_cur);
  assign ahead_step = (dir_q == DIR_DN) ? |(req & below_step) : |(req & above_step);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    floor_d = floor_q;
    tcnt_d  = tcnt_q;
    dcnt_d  = dcnt_q;
    served  = '0;
    case (state_q)
      S_IDLE: begin
        if (pending_q[floor_q]) begin
          state_d = S_DOOR;
          dcnt_d  = DOOR_MAX;
          served  = ONE << floor_q;
        end else if (ahead_cur) begin
          state_d = S_MOVE;
          tcnt_d  = TRAVEL_MAX;
        end else if (behind_cur) begin
          dir_d   = ~dir_q;
          state_d = S_MOVE;
          tcnt_d  = TRAVEL_MAX;
        end
      end
      S_MOVE: begin
        if (My_Clock) begin
          if (tcnt_q == '0) begin
            floor_d = floor_step;
            tcnt_d  = TRAVEL_MAX;
            if (req[floor_step]) begin
              state_d = S_DOOR;
              dcnt_d  = DOOR_MAX;
              served  = ONE << floor_step;
            end else if (!ahead_step) begin
              state_d = S_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q - TW'(1);
          end
        end
      end
      S_DOOR: begin
        served = ONE << floor_q;
        if (calls[floor_q] || hold) begin
          dcnt_d = DOOR_MAX;
        end else if (My_Clock) begin
          if (dcnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            dcnt_d = dcnt_q - DW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d = req & ~served;
    engine_d  = 2'b00;
    doors_d   = '0;
    if (state_d == S_MOVE) begin
      engine_d = (dir_d == DIR_DN) ? 2'b10 : 2'b01;
    end
    if (state_d == S_DOOR) begin
      doors_d = ONE << floor_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      dir_q     <= DIR_UP;
      floor_q   <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      pending_q <= '0;
      engine_q  <= 2'b00;
      doors_q   <= '0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      floor_q   <= floor_d;
      tcnt_q    <= tcnt_d;
      dcnt_q    <= dcnt_d;
      pending_q <= pending_d;
      engine_q  <= engine_d;
      doors_q   <= doors_d;
    end
  end

  assign engine  = engine_q;
  assign doors   = doors_q;
  assign floor   = floor_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Scoreboard bench for elevator_controller: expected output snapshots (with strobe gaps) are
// queued by the stimulus and popped by a monitor whenever {engine,doors,floor,pending} changes.
module tb_elevator_controller;

  logic       CLK = 1'b0;
  logic       RST;
  logic       My_Clock;
  logic [3:0] interior_panel;
  logic [3:0] exterior_panel;
  logic [1:0] engine;
  logic [3:0] doors;
  logic [1:0] floor;
  logic [3:0] pending;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       door_hold;
`endif

  elevator_controller #(.FLOORS(4), .TRAVEL_TICKS(2), .DOOR_TICKS(3)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .My_Clock       (My_Clock),
    .interior_panel (interior_panel),
    .exterior_panel (exterior_panel),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold      (door_hold),
`endif
    .engine         (engine),
    .doors          (doors),
    .floor          (floor),
    .pending        (pending)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [1:0] eng;
    logic [3:0] drs;
    logic [1:0] flr;
    logic [3:0] pnd;
  } obs_t;

  typedef struct {
    obs_t  o;
    int    d;     // strobes since previous change; -1 when stimulus-timed
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   cyc  = 0;
  int   scnt = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   mon_en = 0;
  bit   done = 0;

  always @(posedge CLK) if (My_Clock) scnt <= scnt + 1;

  function automatic void ex(logic [1:0] eng, logic [3:0] drs, logic [1:0] flr,
                             logic [3:0] pnd, int d, string tag);
    exp_t e;
    e.o   = {eng, drs, flr, pnd};
    e.d   = d;
    e.tag = tag;
    exp_q.push_back(e);
  endfunction

  // Monitor: one comparison per observed output change, plus a final drain check.
  obs_t prev;
  bit   have_prev = 0;
  int   last_s = 0;
  always @(negedge CLK) begin
    obs_t cur;
    exp_t e;
    int   d;
    if (mon_en) begin
      cur = {engine, doors, floor, pending};
      if (!have_prev || cur != prev) begin
        d = scnt - last_s;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected: got eng=%b doors=%b floor=%0d pend=%b, required no change",
                   cur.eng, cur.drs, cur.flr, cur.pnd);
        end else begin
          e = exp_q.pop_front();
          if (cur != e.o || (e.d >= 0 && d != e.d)) begin
            n_err++;
            $display("FAIL %s: got eng=%b doors=%b floor=%0d pend=%b gap=%0d, required eng=%b doors=%b floor=%0d pend=%b gap=%0d",
                     e.tag, cur.eng, cur.drs, cur.flr, cur.pnd, d,
                     e.o.eng, e.o.drs, e.o.flr, e.o.pnd, e.d);
          end else begin
            $display("ok %s: eng=%b doors=%b floor=%0d pend=%b gap=%0d",
                     e.tag, cur.eng, cur.drs, cur.flr, cur.pnd, d);
          end
        end
        prev      = cur;
        have_prev = 1;
        last_s    = scnt;
      end
      if (done) begin
        n_vec++;
        if (exp_q.size() != 0) begin
          n_err++;
          $display("FAIL drain: got %0d outstanding events, required 0 (next %s)",
                   exp_q.size(), exp_q[0].tag);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
    end
  end

  // Strobe on every edge whose index is a multiple of 4.
  task automatic tick();
    @(negedge CLK);
    cyc++;
    My_Clock = (cyc % 4 == 0);
  endtask

  task automatic wait_to(int c);
    while (cyc < c) tick();
  endtask

  // Panel pulse sampled by the DUT on edge c.
  task automatic press_at(int c, logic [3:0] ip, logic [3:0] ep);
    wait_to(c);
    interior_panel = ip;
    exterior_panel = ep;
    tick();
    interior_panel = '0;
    exterior_panel = '0;
  endtask

  // Next edge index one past a strobe edge, with some slack.
  function automatic int next_e0();
    return ((cyc / 4) + 2) * 4 + 1;
  endfunction

  initial begin
    int e0;
    RST = 1'b1;
    My_Clock = 1'b0;
    interior_panel = '0;
    exterior_panel = '0;
`ifdef ELEVATOR_DOOR_HOLD_EN
    door_hold = 1'b0;
`endif
    repeat (5) tick();
    ex(2'b00, 4'b0000, 2'd0, 4'b0000, -1, "reset");
    RST = 1'b0;
    mon_en = 1;
    repeat (50) tick();

    // 0 -> 3 on an interior call
    e0 = next_e0();
    ex(2'b00, 4'b0000, 2'd0, 4'b1000, -1, "b_latch");
    ex(2'b01, 4'b0000, 2'd0, 4'b1000,  0, "b_depart");
    ex(2'b01, 4'b0000, 2'd1, 4'b1000,  2, "b_f1");
    ex(2'b01, 4'b0000, 2'd2, 4'b1000,  2, "b_f2");
    ex(2'b00, 4'b1000, 2'd3, 4'b0000,  2, "b_arrive3");
    ex(2'b00, 4'b0000, 2'd3, 4'b0000,  3, "b_close");
    press_at(e0, 4'b1000, 4'b0000);
    wait_to(e0 + 45);

    // Door reload at floor 3 on dwell strobe 2
    e0 = next_e0();
    ex(2'b00, 4'b0000, 2'd3, 4'b1000, -1, "r_latch");
    ex(2'b00, 4'b1000, 2'd3, 4'b0000,  0, "r_open");
    ex(2'b00, 4'b0000, 2'd3, 4'b0000,  5, "r_close5");
    press_at(e0, 4'b1000, 4'b0000);
    press_at(e0 + 7, 4'b1000, 4'b0000);
    wait_to(e0 + 30);

    // 3 -> 0 with direction flip
    e0 = next_e0();
    ex(2'b00, 4'b0000, 2'd3, 4'b0001, -1, "d_latch");
    ex(2'b10, 4'b0000, 2'd3, 4'b0001,  0, "d_depart");
    ex(2'b10, 4'b0000, 2'd2, 4'b0001,  2, "d_f2");
    ex(2'b10, 4'b0000, 2'd1, 4'b0001,  2, "d_f1");
    ex(2'b00, 4'b0001, 2'd0, 4'b0000,  2, "d_arrive0");
    ex(2'b00, 4'b0000, 2'd0, 4'b0000,  3, "d_close");
    press_at(e0, 4'b0000, 4'b0001);
    wait_to(e0 + 45);

    // Intermediate stop at 1, then call behind at 2 -> serve 3, reverse to 0 non-stop
    e0 = next_e0();
    ex(2'b00, 4'b0000, 2'd0, 4'b1000, -1, "c_latch");
    ex(2'b01, 4'b0000, 2'd0, 4'b1000,  0, "c_depart");
    ex(2'b01, 4'b0000, 2'd0, 4'b1010,  1, "c_ext1");
    ex(2'b00, 4'b0010, 2'd1, 4'b1000,  1, "c_stop1");
    ex(2'b00, 4'b0000, 2'd1, 4'b1000,  3, "c_close1");
    ex(2'b01, 4'b0000, 2'd1, 4'b1000,  0, "c_resume");
    ex(2'b01, 4'b0000, 2'd2, 4'b1000,  2, "c_f2");
    ex(2'b01, 4'b0000, 2'd2, 4'b1001,  0, "c_call0");
    ex(2'b00, 4'b1000, 2'd3, 4'b0001,  2, "c_arrive3");
    ex(2'b00, 4'b0000, 2'd3, 4'b0001,  3, "c_close3");
    ex(2'b10, 4'b0000, 2'd3, 4'b0001,  0, "c_reverse");
    ex(2'b10, 4'b0000, 2'd2, 4'b0001,  2, "c_pass2");
    ex(2'b10, 4'b0000, 2'd1, 4'b0001,  2, "c_pass1");
    ex(2'b00, 4'b0001, 2'd0, 4'b0000,  2, "c_arrive0");
    ex(2'b00, 4'b0000, 2'd0, 4'b0000,  3, "c_close0");
    press_at(e0, 4'b1000, 4'b0000);
    press_at(e0 + 5, 4'b0000, 4'b0010);
    press_at(e0 + 29, 4'b0000, 4'b0001);
    wait_to(e0 + 95);

    // Reset mid-move at floor 2, coinciding with a strobe
    e0 = next_e0();
    ex(2'b00, 4'b0000, 2'd0, 4'b1000, -1, "x_latch");
    ex(2'b01, 4'b0000, 2'd0, 4'b1000,  0, "x_depart");
    ex(2'b01, 4'b0000, 2'd1, 4'b1000,  2, "x_f1");
    ex(2'b01, 4'b0000, 2'd2, 4'b1000,  2, "x_f2");
    ex(2'b00, 4'b0000, 2'd0, 4'b0000,  1, "x_reset");
    press_at(e0, 4'b1000, 4'b0000);
    wait_to(e0 + 19);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    wait_to(e0 + 40);

`ifdef ELEVATOR_DOOR_HOLD_EN
    // Door held through 10 strobes, then 3 more to close
    e0 = next_e0();
    ex(2'b00, 4'b0000, 2'd0, 4'b0001, -1, "h_latch");
    ex(2'b00, 4'b0001, 2'd0, 4'b0000,  0, "h_open");
    ex(2'b00, 4'b0000, 2'd0, 4'b0000, 13, "h_close13");
    press_at(e0, 4'b0001, 4'b0000);
    wait_to(e0 + 2);
    door_hold = 1'b1;
    wait_to(e0 + 40);
    door_hold = 1'b0;
    wait_to(e0 + 60);
`endif

    done = 1;
  end

endmodule

// File: doc/elevator_controller.md
# elevator_controller

Parametrised successor to the three-floor `movement` block: a single-car elevator controller for `FLOORS` landings. It latches interior and exterior call buttons into a pending-request register and schedules service with a SCAN (keep-direction) policy. It also times travel between floors and door dwell from the slow `My_Clock` step strobe, and drives the engine and per-floor door outputs. It sits between the panel debouncers and the motor/door drivers.

## Interface
- `FLOORS`, default 4: number of landings; must be ≥ 2.
- `TRAVEL_TICKS`, default 2: `My_Clock` strobes needed to move one floor; must be ≥ 1.
- `DOOR_TICKS`, default 3: `My_Clock` strobes the door stays open; must be ≥ 1.
- `CLK` in 1: system clock; all logic is on the rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `My_Clock` in 1: one-`CLK`-wide step strobe; all travel and door timing counts these.
- `interior_panel` in `FLOORS`: car buttons; bit i calls floor i. Level or pulse.
- `exterior_panel` in `FLOORS`: landing buttons; bit i calls floor i.
- `engine` out 2: 2'b00 stop, 2'b01 up, 2'b10 down. 2'b11 is never driven.
- `doors` out `FLOORS`: one-hot open-door indication at the current floor; all zero when closed.
- `floor` out FW: current floor index, where FW = max(1, $clog2(FLOORS)).
- `pending` out `FLOORS`: latched unserved requests.

## Operation
- Request latch, every `CLK`: `pending <= (pending | interior_panel | exterior_panel) & ~served`.
  - `served` is the one-hot of `floor` in the cycle a door-open event occurs.
- State machine: IDLE, MOVE, DOOR.
  - **IDLE**, evaluated on every `CLK`, not gated by the strobe:
    - If `pending[floor]` is set, go to DOOR.
    - Else, if there is a request in direction `dir`, go to MOVE in `dir`.
    - Else, if there is a request in the opposite direction, flip `dir` and go to MOVE.
    - Else, stay in IDLE.
  - **MOVE**: `engine` = `dir`. On each `My_Clock`, `tcnt` decrements. At zero, `floor` steps ±1 and `tcnt` reloads to `TRAVEL_TICKS-1`.
    - After a step, if `pending[new floor]` is set, go to DOOR with `engine` = 00.
    - Otherwise keep moving and pass the floor through.
  - **DOOR**: `doors` = one-hot(`floor`), `dcnt` = `DOOR_TICKS-1`, and the floor bit clears.
    - Each `My_Clock` decrements `dcnt`. On the strobe where `dcnt` = 0, go to IDLE and drive `doors` to 0.
    - A new call for the current floor while in DOOR clears immediately and reloads `dcnt` to `DOOR_TICKS-1`.
- Direction register `dir` (up/down) resets to up. It flips only in IDLE when no request is ahead.
- Bounds: `floor` never leaves [0, FLOORS-1]. The scheduler cannot request a move past an end. Reaching floor 0 or FLOORS-1 forces a stop evaluation.

## Timing
- Reset values: `engine` = 00, `doors` = 0, `floor` = 0, `pending` = 0, `dir` = up, state = IDLE, counters = 0.
- Panel bit high in cycle N appears in `pending` at N+1.
- An IDLE decision is made in N+1, and `engine`/`doors` update at N+2.
- All outputs are registered.
- A one-floor move takes exactly `TRAVEL_TICKS` strobes. `doors` asserts in the cycle after the arrival strobe.
- The door is open for exactly `DOOR_TICKS` strobes, unless it is reloaded.
- Simultaneous events:
  - Arrival and a request for the arrival floor in the same cycle: the floor is served at this stop.
  - Strobe and reset in the same cycle: reset wins.
- A request for a floor just departed stays pending and is served after the SCAN reversal.
- `RST` mid-move or mid-door: all state clears and `floor` returns to 0, since there is no position sensor. Pending calls are lost.

## Configuration
- `ELEVATOR_DOOR_HOLD_EN` defined:
  - Adds input `door_hold` (1 bit).
  - While `door_hold` = 1 in DOOR, `dcnt` reloads to `DOOR_TICKS-1` every cycle. The door cannot close and the car cannot leave.
- Not defined: the port is absent and the door closes purely on timer.

## Test plan
All scenarios use FLOORS=4, TRAVEL_TICKS=2, DOOR_TICKS=3, with `My_Clock` pulsing every 4 `CLK`.
- Reset, then no calls for 50 cycles -> `engine` = 00, `doors` = 0, `floor` = 0, `pending` = 0 throughout.
- `interior_panel` = 4'b1000 for one cycle at floor 0:
  - `engine` = 01 for 6 strobes, then `floor` = 3 and `doors` = 4'b1000 for 3 strobes.
  - Then IDLE with `pending` = 0.
- At floor 0, move toward 3; during travel, pulse `exterior_panel[1]` before floor 1 is reached -> stop at 1 (`doors` = 4'b0010), then resume to 3.
- At floor 2 moving up to 3, press floor 0 -> service 3 first, flip `dir`, descend to 0 without stopping at 2 or 1.
- Door open at floor 3, press `interior_panel[3]` on dwell strobe 2 -> dwell restarts and totals 5 strobes; `pending[3]` stays 0.
- Assert `RST` while `floor` = 2 and `engine` = 01 -> next cycle `floor` = 0, `engine` = 00, `pending` = 0.
- With `ELEVATOR_DOOR_HOLD_EN`: hold `door_hold` for 10 strobes -> `doors` stays open 10+3 strobes.
